// File: rtl/dram_axi_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_axi_gate: AXI4 calibration gate, outstanding-burst limiter and       |
// | drain controller in front of the DRAM controller slave port.              |
// | Optional perf counters: DRAM_AXI_GATE_PERF_EN                             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

package dram_axi_gate_pkg;
    typedef struct packed {
        logic [5:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;
endpackage

module dram_axi_gate #(
    parameter type         axi_req_t     = dram_axi_gate_pkg::axi_req_t,
    parameter type         axi_resp_t    = dram_axi_gate_pkg::axi_resp_t,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DramAddrWidth = 32,
    parameter int unsigned MaxReadTxns   = 8,
    parameter int unsigned MaxWriteTxns  = 8,
    parameter int unsigned CalibTimeout  = 2**20
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                calib_done_i,
    input  logic                                flush_i,
    input  axi_req_t                            slv_req_i,
    output axi_resp_t                           slv_rsp_o,
    output axi_req_t                            mst_req_o,
    input  axi_resp_t                           mst_rsp_i,
    output logic [1:0]                          state_o,
    output logic [$clog2(MaxReadTxns+1)-1:0]    rd_outstanding_o,
    output logic [$clog2(MaxWriteTxns+1)-1:0]   wr_outstanding_o,
    output logic                                calib_timeout_o,
`ifdef DRAM_AXI_GATE_PERF_EN
    output logic [31:0]                         rd_beats_o,
    output logic [31:0]                         wr_beats_o,
    output logic [31:0]                         stall_cycles_o,
`endif
    output logic                                idle_o
);

    localparam int unsigned c_rd_w  = $clog2(MaxReadTxns+1);
    localparam int unsigned c_wr_w  = $clog2(MaxWriteTxns+1);
    localparam int unsigned c_tmo_w = (CalibTimeout > 1) ? $clog2(CalibTimeout) : 1;

    localparam logic [c_rd_w-1:0]    c_rd_max    = c_rd_w'(MaxReadTxns);
    localparam logic [c_wr_w-1:0]    c_wr_max    = c_wr_w'(MaxWriteTxns);
    localparam logic [c_tmo_w-1:0]   c_tmo_last  = c_tmo_w'(CalibTimeout - 1);
    localparam logic [AddrWidth-1:0] c_addr_mask = {AddrWidth{1'b1}} >> (AddrWidth - DramAddrWidth);

    localparam logic [1:0] c_st_wait_calib = 2'd0;
    localparam logic [1:0] c_st_run        = 2'd1;
    localparam logic [1:0] c_st_drain      = 2'd2;
    localparam logic [1:0] c_st_hold       = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_rd_w-1:0]  r_rd_cnt;
    logic [c_wr_w-1:0]  r_wr_cnt;
    logic [c_wr_w-1:0]  r_wdat_cnt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_calib_timeout;

    logic w_ar_admit, w_aw_admit, w_w_open;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_w_last_hs, w_r_hs, w_r_last_hs, w_b_hs;
    logic w_drained;

    assign w_ar_admit = !rst_i && (r_state == c_st_run) && (r_rd_cnt < c_rd_max);
    assign w_aw_admit = !rst_i && (r_state == c_st_run) && (r_wr_cnt < c_wr_max);
    assign w_w_open   = !rst_i && (r_wdat_cnt != '0);

    // Payloads pass straight through; only valids/readies are gated and the
    // address bits above the DRAM window are cleared.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw.addr  = slv_req_i.aw.addr & c_addr_mask;
        mst_req_o.ar.addr  = slv_req_i.ar.addr & c_addr_mask;
        mst_req_o.ar_valid = slv_req_i.ar_valid & w_ar_admit;
        mst_req_o.aw_valid = slv_req_i.aw_valid & w_aw_admit;
        mst_req_o.w_valid  = slv_req_i.w_valid & w_w_open;

        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & w_ar_admit;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & w_aw_admit;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_w_open;

        if (rst_i) begin
            mst_req_o.b_ready = 1'b0;
            mst_req_o.r_ready = 1'b0;
            slv_rsp_o.b_valid = 1'b0;
            slv_rsp_o.r_valid = 1'b0;
        end
    end

    assign w_ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
    assign w_aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
    assign w_w_hs      = mst_req_o.w_valid & mst_rsp_i.w_ready;
    assign w_w_last_hs = w_w_hs & slv_req_i.w.last;
    assign w_r_hs      = slv_rsp_o.r_valid & slv_req_i.r_ready;
    assign w_r_last_hs = w_r_hs & mst_rsp_i.r.last;
    assign w_b_hs      = slv_rsp_o.b_valid & slv_req_i.b_ready;

    assign w_drained = (r_rd_cnt == '0) && (r_wr_cnt == '0) && (r_wdat_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_wait_calib: if (calib_done_i && !flush_i) w_state_nxt = c_st_run;
            c_st_run:        if (flush_i || !calib_done_i) w_state_nxt = c_st_drain;
            c_st_drain:      if (w_drained) w_state_nxt = calib_done_i ? c_st_hold : c_st_wait_calib;
            c_st_hold: begin
                if (!calib_done_i) w_state_nxt = c_st_wait_calib;
                else if (!flush_i) w_state_nxt = c_st_run;
            end
            default:         w_state_nxt = c_st_wait_calib;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= c_st_wait_calib;
            r_rd_cnt        <= '0;
            r_wr_cnt        <= '0;
            r_wdat_cnt      <= '0;
            r_tmo_cnt       <= '0;
            r_calib_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            case ({w_ar_hs, w_r_last_hs})
                2'b10:   r_rd_cnt <= r_rd_cnt + c_rd_w'(1);
                2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - c_rd_w'(1);
                default: ;
            endcase

            case ({w_aw_hs, w_b_hs})
                2'b10:   r_wr_cnt <= r_wr_cnt + c_wr_w'(1);
                2'b01:   if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - c_wr_w'(1);
                default: ;
            endcase

            case ({w_aw_hs, w_w_last_hs})
                2'b10:   r_wdat_cnt <= r_wdat_cnt + c_wr_w'(1);
                2'b01:   if (r_wdat_cnt != '0) r_wdat_cnt <= r_wdat_cnt - c_wr_w'(1);
                default: ;
            endcase

            // Timer saturates at its last value; the flag is sticky until reset.
            if (r_state == c_st_wait_calib) begin
                if (r_tmo_cnt == c_tmo_last) r_calib_timeout <= 1'b1;
                else                         r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_r_last_hs && !w_ar_hs && r_rd_cnt == '0));
            assert (!(w_b_hs && !w_aw_hs && r_wr_cnt == '0));
        end
    end
`endif

`ifdef DRAM_AXI_GATE_PERF_EN
    logic [31:0] r_rd_beats, r_wr_beats, r_stall_cycles;
    logic        w_stall;

    assign w_stall = (slv_req_i.ar_valid && !w_ar_admit) || (slv_req_i.aw_valid && !w_aw_admit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_beats     <= '0;
            r_wr_beats     <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_r_hs)  r_rd_beats     <= r_rd_beats + 32'd1;
            if (w_w_hs)  r_wr_beats     <= r_wr_beats + 32'd1;
            if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign rd_beats_o     = r_rd_beats;
    assign wr_beats_o     = r_wr_beats;
    assign stall_cycles_o = r_stall_cycles;
`endif

    assign state_o          = r_state;
    assign rd_outstanding_o = r_rd_cnt;
    assign wr_outstanding_o = r_wr_cnt;
    assign calib_timeout_o  = r_calib_timeout;
    assign idle_o           = (r_rd_cnt == '0) && (r_wr_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_dram_axi_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dram_axi_gate: directed scoreboard bench for dram_axi_gate.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dram_axi_gate;
    import dram_axi_gate_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      calib_done;
    logic      flush;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_rsp, mst_rsp;
    logic [1:0] state;
    logic [1:0] rd_out;
    logic [1:0] wr_out;
    logic       calib_timeout;
    logic       idle;
`ifdef DRAM_AXI_GATE_PERF_EN
    logic [31:0] rd_beats, wr_beats, stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] exp_ar_q[$];
    logic [47:0] exp_aw_q[$];
    logic [63:0] exp_w_q[$];
    logic [63:0] exp_r_q[$];
    logic [5:0]  exp_b_q[$];

    always #5 clk = ~clk;

    dram_axi_gate #(
        .axi_req_t     (axi_req_t),
        .axi_resp_t    (axi_resp_t),
        .AddrWidth     (48),
        .DramAddrWidth (32),
        .MaxReadTxns   (3),
        .MaxWriteTxns  (2),
        .CalibTimeout  (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .calib_done_i     (calib_done),
        .flush_i          (flush),
        .slv_req_i        (slv_req),
        .slv_rsp_o        (slv_rsp),
        .mst_req_o        (mst_req),
        .mst_rsp_i        (mst_rsp),
        .state_o          (state),
        .rd_outstanding_o (rd_out),
        .wr_outstanding_o (wr_out),
        .calib_timeout_o  (calib_timeout),
`ifdef DRAM_AXI_GATE_PERF_EN
        .rd_beats_o       (rd_beats),
        .wr_beats_o       (wr_beats),
        .stall_cycles_o   (stall_cycles),
`endif
        .idle_o           (idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got transfer %0h, required none", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mst_req.ar_valid && mst_rsp.ar_ready) begin
                if (exp_ar_q.size() == 0) unexpected("ar_unexpected", 64'(mst_req.ar.addr));
                else check("ar_addr", 64'(mst_req.ar.addr), 64'(exp_ar_q.pop_front()));
            end
            if (mst_req.aw_valid && mst_rsp.aw_ready) begin
                if (exp_aw_q.size() == 0) unexpected("aw_unexpected", 64'(mst_req.aw.addr));
                else check("aw_addr", 64'(mst_req.aw.addr), 64'(exp_aw_q.pop_front()));
            end
            if (mst_req.w_valid && mst_rsp.w_ready) begin
                if (exp_w_q.size() == 0) unexpected("w_unexpected", mst_req.w.data);
                else check("w_data", mst_req.w.data, exp_w_q.pop_front());
            end
            if (slv_rsp.r_valid && slv_req.r_ready) begin
                if (exp_r_q.size() == 0) unexpected("r_unexpected", slv_rsp.r.data);
                else check("r_data", slv_rsp.r.data, exp_r_q.pop_front());
            end
            if (slv_rsp.b_valid && slv_req.b_ready) begin
                if (exp_b_q.size() == 0) unexpected("b_unexpected", 64'(slv_rsp.b.id));
                else check("b_id", 64'(slv_rsp.b.id), 64'(exp_b_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; calib_done = 1'b0; flush = 1'b0;
        slv_req = '0; mst_rsp = '0;
        repeat (3) step();
        check("rst_state", 64'(state), 0);
        check("rst_idle", 64'(idle), 1);
        check("rst_rd", 64'(rd_out), 0);
        check("rst_wr", 64'(wr_out), 0);
        check("rst_tmo", 64'(calib_timeout), 0);
        check("rst_b_valid", 64'(slv_rsp.b_valid), 0);
        rst = 1'b0;

        // Calibration hold-off and timeout
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 48'h12_8000_0040;
        mst_rsp.ar_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            check("wc_state", 64'(state), 0);
            check("wc_ar_ready", 64'(slv_rsp.ar_ready), 0);
            check("wc_mst_ar_valid", 64'(mst_req.ar_valid), 0);
            check("wc_timeout", 64'(calib_timeout), (i >= 16) ? 64'd1 : 64'd0);
        end
        exp_ar_q.push_back(48'h00_8000_0040);
        calib_done = 1'b1;
        #1;
        check("calib_edge_ar_ready", 64'(slv_rsp.ar_ready), 0);
        step();
        check("run_state", 64'(state), 1);
        check("run_ar_valid", 64'(mst_req.ar_valid), 1);
        check("run_ar_ready", 64'(slv_rsp.ar_ready), 1);
        check("tmo_sticky", 64'(calib_timeout), 1);
        step();
        slv_req.ar_valid = 1'b0;
        #1;
        check("rd_one", 64'(rd_out), 1);
        check("not_idle", 64'(idle), 0);

        slv_req.r_ready  = 1'b1;
        slv_req.b_ready  = 1'b1;
        mst_rsp.r_valid  = 1'b1;
        mst_rsp.r.last   = 1'b1;
        mst_rsp.r.data   = 64'hA5A5_0001;
        exp_r_q.push_back(64'hA5A5_0001);
        step();
        mst_rsp.r_valid = 1'b0;
        #1;
        check("rd_zero", 64'(rd_out), 0);
        check("idle_back", 64'(idle), 1);

        // Outstanding read limit
        slv_req.ar_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            slv_req.ar.addr = 48'hFFFF_0000_1000 + 48'(k * 'h100);
            exp_ar_q.push_back(48'h0000_0000_1000 + 48'(k * 'h100));
            step();
        end
        slv_req.ar.addr = 48'hAB_CDEF_0123;
        #1;
        check("rd_full", 64'(rd_out), 3);
        check("full_ar_ready", 64'(slv_rsp.ar_ready), 0);
        check("full_mst_ar_valid", 64'(mst_req.ar_valid), 0);
        step();
        check("full_ar_ready_2", 64'(slv_rsp.ar_ready), 0);
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.data  = 64'hA5A5_0002;
        exp_r_q.push_back(64'hA5A5_0002);
        #1;
        check("full_r_cycle_ar_ready", 64'(slv_rsp.ar_ready), 0);
        step();
        mst_rsp.r_valid = 1'b0;
        exp_ar_q.push_back(48'h00_CDEF_0123);
        #1;
        check("rd_two", 64'(rd_out), 2);
        check("reopen_ar_ready", 64'(slv_rsp.ar_ready), 1);
        step();
        slv_req.ar_valid = 1'b0;
        #1;
        check("rd_refull", 64'(rd_out), 3);

        // Simultaneous AR and R last at rd_cnt=1
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.data  = 64'hA5A5_0003;
        exp_r_q.push_back(64'hA5A5_0003);
        step();
        mst_rsp.r.data  = 64'hA5A5_0004;
        exp_r_q.push_back(64'hA5A5_0004);
        step();
        mst_rsp.r_valid = 1'b0;
        #1;
        check("rd_one_b", 64'(rd_out), 1);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 48'h0000_0000_2000;
        exp_ar_q.push_back(48'h0000_0000_2000);
        mst_rsp.r_valid  = 1'b1;
        mst_rsp.r.data   = 64'hA5A5_0005;
        exp_r_q.push_back(64'hA5A5_0005);
        #1;
        check("simul_ar_ready", 64'(slv_rsp.ar_ready), 1);
        step();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r_valid  = 1'b0;
        #1;
        check("simul_rd_same", 64'(rd_out), 1);
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.data  = 64'hA5A5_0006;
        exp_r_q.push_back(64'hA5A5_0006);
        step();
        mst_rsp.r_valid = 1'b0;
        #1;
        check("rd_zero_b", 64'(rd_out), 0);

        // W before AW
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 64'h1111_0000;
        slv_req.w.last   = 1'b0;
        mst_rsp.w_ready  = 1'b1;
        mst_rsp.aw_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("early_w_ready", 64'(slv_rsp.w_ready), 0);
            check("early_mst_w_valid", 64'(mst_req.w_valid), 0);
            step();
        end
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 48'h7F_0000_8000;
        exp_aw_q.push_back(48'h00_0000_8000);
        #1;
        check("aw_cycle_w_ready", 64'(slv_rsp.w_ready), 0);
        check("aw_ready", 64'(slv_rsp.aw_ready), 1);
        step();
        slv_req.aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            slv_req.w.data = 64'h1111_0000 + 64'(b);
            slv_req.w.last = (b == 3);
            exp_w_q.push_back(64'h1111_0000 + 64'(b));
            #1;
            check("burst_w_ready", 64'(slv_rsp.w_ready), 1);
            check("burst_wr_out", 64'(wr_out), 1);
            step();
        end
        slv_req.w.data = 64'h2222;
        slv_req.w.last = 1'b0;
        #1;
        check("post_w_ready", 64'(slv_rsp.w_ready), 0);
        check("post_wr_out", 64'(wr_out), 1);
        slv_req.w_valid = 1'b0;
        mst_rsp.b_valid = 1'b1;
        mst_rsp.b.id    = 6'd3;
        exp_b_q.push_back(6'd3);
        step();
        mst_rsp.b_valid = 1'b0;
        #1;
        check("wr_zero", 64'(wr_out), 0);
        check("idle_w", 64'(idle), 1);

        // Flush with 3 reads and 1 write outstanding
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 48'h00_0000_3000;
        exp_ar_q.push_back(48'h00_0000_3000);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 48'h00_0000_4000;
        exp_aw_q.push_back(48'h00_0000_4000);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.ar.addr  = 48'h00_0000_3100;
        exp_ar_q.push_back(48'h00_0000_3100);
        step();
        slv_req.ar.addr  = 48'h00_0000_3200;
        exp_ar_q.push_back(48'h00_0000_3200);
        step();
        slv_req.ar_valid = 1'b0;
        #1;
        check("pre_flush_rd", 64'(rd_out), 3);
        check("pre_flush_wr", 64'(wr_out), 1);
        flush = 1'b1;
        step();
        check("drain_state", 64'(state), 2);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 48'h00_0000_5000;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 48'h00_0000_6000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain_ar_ready", 64'(slv_rsp.ar_ready), 0);
            check("drain_aw_ready", 64'(slv_rsp.aw_ready), 0);
            check("drain_mst_aw_valid", 64'(mst_req.aw_valid), 0);
            check("drain_state_hold", 64'(state), 2);
            step();
        end
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = 64'h3333;
        slv_req.w.last  = 1'b1;
        exp_w_q.push_back(64'h3333);
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.data  = 64'hA5A5_0007;
        exp_r_q.push_back(64'hA5A5_0007);
        mst_rsp.b_valid = 1'b1;
        mst_rsp.b.id    = 6'd4;
        exp_b_q.push_back(6'd4);
        step();
        slv_req.w_valid = 1'b0;
        mst_rsp.b_valid = 1'b0;
        mst_rsp.r.data  = 64'hA5A5_0008;
        exp_r_q.push_back(64'hA5A5_0008);
        step();
        mst_rsp.r.data  = 64'hA5A5_0009;
        exp_r_q.push_back(64'hA5A5_0009);
        step();
        mst_rsp.r_valid = 1'b0;
        #1;
        check("drained_idle", 64'(idle), 1);
        check("drained_state", 64'(state), 2);
        step();
        check("hold_state", 64'(state), 3);
        check("hold_idle", 64'(idle), 1);
        check("hold_ar_ready", 64'(slv_rsp.ar_ready), 0);
        check("hold_aw_ready", 64'(slv_rsp.aw_ready), 0);
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b0;
        flush = 1'b0;
        step();
        check("resume_state", 64'(state), 1);

        // Calibration loss: RUN -> DRAIN -> WAIT_CALIB
        calib_done = 1'b0;
        step();
        check("loss_drain", 64'(state), 2);
        step();
        check("loss_wait", 64'(state), 0);

        check("ar_q_empty", 64'(exp_ar_q.size()), 0);
        check("aw_q_empty", 64'(exp_aw_q.size()), 0);
        check("w_q_empty", 64'(exp_w_q.size()), 0);
        check("r_q_empty", 64'(exp_r_q.size()), 0);
        check("b_q_empty", 64'(exp_b_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
